// File: rtl/dpll_ctrl_pkg.sv
// Shared state encoding and default loop constants for the DPLL bandwidth/lock controller.
package dpll_ctrl_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ACQ   = 2'b01,
      SHIFT = 2'b10,
      TRACK = 2'b11
   } ctrlState_e;

   localparam int unsigned DEF_WINDOW  = 65536;
   localparam int unsigned DEF_K_ACQ   = 4;
   localparam int unsigned DEF_K_TRACK = 10;
endpackage

// File: rtl/dlf_event_counter.sv
// Counts rising edges of loop-filter carry/borrow with saturation; exposes the total
// including the current cycle's events so the window-end decision sees them.
module dlf_event_counter #(
   parameter int unsigned EVT_W = 8
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic             carry,
   input  logic             borrow,
   input  logic             restart,
   output logic [EVT_W-1:0] nextTotal
);
   logic             carryQ;
   logic             borrowQ;
   logic [EVT_W-1:0] count;
   logic [1:0]       inc;
   logic [EVT_W:0]   sum;

   always_comb begin
      inc       = {1'b0, carry & ~carryQ} + {1'b0, borrow & ~borrowQ};
      sum       = {1'b0, count} + {{(EVT_W-1){1'b0}}, inc};
      nextTotal = sum[EVT_W] ? '1 : sum[EVT_W-1:0];
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         carryQ  <= 1'b0;
         borrowQ <= 1'b0;
         count   <= '0;
      end else begin
         carryQ  <= carry;
         borrowQ <= borrow;
         count   <= restart ? '0 : nextTotal;
      end
   end
endmodule

// File: rtl/dpll_loop_ctrl.sv
// Gear-shift and lock controller: wide K during acquisition, narrow K once quiet,
// with loop-filter clears around every modulus change.
module dpll_loop_ctrl
   import dpll_ctrl_pkg::*;
#(
   parameter int unsigned WINDOW       = DEF_WINDOW,
   parameter int unsigned WIN_W        = 20,
   parameter int unsigned EVT_W        = 8,
   parameter int unsigned LOCK_THR     = 4,
   parameter int unsigned UNLOCK_THR   = 32,
   parameter int unsigned LOCK_WINDOWS = 4,
   parameter int unsigned SETTLE       = 16,
   parameter int unsigned K_W          = 4,
   parameter int unsigned K_ACQ        = DEF_K_ACQ,
   parameter int unsigned K_TRACK      = DEF_K_TRACK
) (
   input  logic             oscInput,
   input  logic             reset,
   input  logic             enable,
   input  logic             dlfCarry,
   input  logic             dlfBorrow,
   output logic [K_W-1:0]   kExp,
   output logic             dlfClear,
   output logic             locked,
   output logic [1:0]       state,
   output logic [EVT_W-1:0] eventCount
);
   localparam int unsigned QW = $clog2(LOCK_WINDOWS + 1);
   localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [K_W-1:0] KA = K_W'(K_ACQ);
   localparam logic [K_W-1:0] KT = K_W'(K_TRACK);

   ctrlState_e       curState, nextState;
   logic [WIN_W-1:0] winCnt;
   logic [QW-1:0]    quietCnt;
   logic [SW-1:0]    settleCnt;
   logic [EVT_W-1:0] evTotal;
   logic             counting, winEnd, quietWin, unlockWin, lockReached, settleDone;
   logic             stateChange, evRestart;
   logic [K_W-1:0]   kExpNext;
   logic             clearNext, lockedNext;

   assign counting    = (curState == ACQ) || (curState == TRACK);
   assign winEnd      = counting && (32'(winCnt) == WINDOW - 1);
   assign quietWin    = 32'(evTotal) <= LOCK_THR;
   assign unlockWin   = 32'(evTotal) >= UNLOCK_THR;
   assign lockReached = 32'(quietCnt) + 1 >= LOCK_WINDOWS;
   assign settleDone  = 32'(settleCnt) == SETTLE - 1;
   assign stateChange = nextState != curState;
   assign evRestart   = stateChange || winEnd || !counting;
   assign state       = curState;

   dlf_event_counter #(.EVT_W(EVT_W)) uEvents (
      .clk       (oscInput),
      .rstN      (reset),
      .carry     (dlfCarry),
      .borrow    (dlfBorrow),
      .restart   (evRestart),
      .nextTotal (evTotal)
   );

   always_comb begin
      nextState = curState;
      case (curState)
         IDLE:    if (enable) nextState = ACQ;
         ACQ:     if (winEnd && quietWin && lockReached) nextState = SHIFT;
         SHIFT:   if (settleDone) nextState = TRACK;
         TRACK:   if (winEnd && unlockWin) nextState = ACQ;
         default: nextState = IDLE;
      endcase
      if (!enable) nextState = IDLE;

      // Outputs are decoded from the next state so they register alongside it.
      kExpNext   = ((nextState == SHIFT) || (nextState == TRACK)) ? KT : KA;
      lockedNext = nextState == TRACK;
      clearNext  = (nextState == IDLE) || (nextState == SHIFT) ||
                   ((nextState == ACQ) && (curState == TRACK));
   end

   always_ff @(posedge oscInput or negedge reset) begin
      if (!reset) begin
         curState <= IDLE;
         kExp     <= KA;
         dlfClear <= 1'b1;
         locked   <= 1'b0;
      end else begin
         curState <= nextState;
         kExp     <= kExpNext;
         dlfClear <= clearNext;
         locked   <= lockedNext;
      end
   end

   always_ff @(posedge oscInput or negedge reset) begin
      if (!reset) begin
         winCnt     <= '0;
         quietCnt   <= '0;
         settleCnt  <= '0;
         eventCount <= '0;
      end else begin
         winCnt <= (stateChange || !counting || winEnd) ? '0 : winCnt + 1'b1;

         if ((curState != ACQ) || stateChange) quietCnt <= '0;
         else if (winEnd) quietCnt <= quietWin ? quietCnt + 1'b1 : '0;

         settleCnt <= ((curState == SHIFT) && !stateChange) ? settleCnt + 1'b1 : '0;

         if (winEnd) eventCount <= evTotal;
      end
   end
endmodule

// File: tb/tb_dpll_loop_ctrl.sv
// Directed bench for dpll_loop_ctrl: cycle-tagged expectations queued by the stimulus,
// popped and compared by an independent monitor.
module tb_dpll_loop_ctrl;
  import dpll_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset, enable, carry, borrow;
  logic [3:0] kExp, kExpS;
  logic       clr, clrS, lck, lckS;
  logic [1:0] st, stS;
  logic [7:0] ev;
  logic [2:0] evS;

  int unsigned cyc        = 0;
  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  typedef struct {
    int unsigned t;
    string       name;
    logic [19:0] exp;
    logic [19:0] mask;
  } chk_t;
  chk_t sb[$];

  localparam logic [19:0] ALL  = 20'hFFFFF;
  localparam logic [19:0] NOEV = 20'hFF800;

  always #5 clk = ~clk;

  dpll_loop_ctrl #(
    .WINDOW(16), .WIN_W(5), .EVT_W(8), .LOCK_THR(1), .UNLOCK_THR(4),
    .LOCK_WINDOWS(2), .SETTLE(4), .K_W(4), .K_ACQ(3), .K_TRACK(8)
  ) dut (
    .oscInput(clk), .reset(reset), .enable(enable), .dlfCarry(carry), .dlfBorrow(borrow),
    .kExp(kExp), .dlfClear(clr), .locked(lck), .state(st), .eventCount(ev)
  );

  dpll_loop_ctrl #(
    .WINDOW(16), .WIN_W(5), .EVT_W(3), .LOCK_THR(1), .UNLOCK_THR(4),
    .LOCK_WINDOWS(2), .SETTLE(4), .K_W(4), .K_ACQ(3), .K_TRACK(8)
  ) dutSat (
    .oscInput(clk), .reset(reset), .enable(enable), .dlfCarry(carry), .dlfBorrow(borrow),
    .kExp(kExpS), .dlfClear(clrS), .locked(lckS), .state(stS), .eventCount(evS)
  );

  // Layout: agree | state | kExp | dlfClear | locked | eventCount(8) | saturating eventCount(3)
  function automatic logic [19:0] mk(logic [1:0] s, logic [3:0] k, logic c, logic l, int unsigned e);
    logic [2:0] sat;
    sat = (e > 7) ? 3'd7 : 3'(e);
    return {1'b1, s, k, c, l, 8'(e), sat};
  endfunction

  task automatic expectAt(int unsigned t, string name, logic [19:0] e, logic [19:0] m);
    chk_t c;
    c.t = t; c.name = name; c.exp = e; c.mask = m;
    sb.push_back(c);
  endtask

  task automatic toCyc(int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin : monitor
    logic [19:0] act;
    logic        agree;
    chk_t        c;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      agree = ({stS, kExpS, clrS, lckS} == {st, kExp, clr, lck});
      act   = {agree, st, kExp, clr, lck, ev, evS};
      while (sb.size() > 0 && sb[0].t <= cyc) begin
        c = sb.pop_front();
        compared++;
        if (c.t < cyc || ((act ^ c.exp) & c.mask) != 20'h0) begin
          mismatched++;
          $display("FAIL %s @cyc %0d: got %h, expected %h (mask %h)",
                   c.name, cyc, act, c.exp, c.mask);
        end
      end
    end
  end

  initial begin : stimulus
    chk_t c;
    reset = 1'b1; enable = 1'b1; carry = 1'b0; borrow = 1'b0;
    #1 reset = 1'b0;

    // 1: reset held with carry toggling, then release
    expectAt(2, "rst_a", mk(IDLE, 4'd3, 1'b1, 1'b0, 0), ALL);
    expectAt(4, "rst_b", mk(IDLE, 4'd3, 1'b1, 1'b0, 0), ALL);
    expectAt(6, "rst_c", mk(IDLE, 4'd3, 1'b1, 1'b0, 0), ALL);
    for (int unsigned i = 1; i <= 5; i++) begin
      toCyc(i);
      carry = ~carry;
    end
    toCyc(6);
    compared++;
    if (st !== 2'b00) begin
      mismatched++;
      $display("FAIL rst_state: got %b", st);
    end
    compared++;
    if (kExp !== 4'd3) begin
      mismatched++;
      $display("FAIL rst_kexp: got %0d", kExp);
    end
    compared++;
    if (clr !== 1'b1) begin
      mismatched++;
      $display("FAIL rst_clear: got %b", clr);
    end
    compared++;
    if (lck !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_locked: got %b", lck);
    end
    reset = 1'b1; carry = 1'b0;

    // 2: two quiet windows -> SHIFT for 4 cycles -> TRACK
    expectAt(7,  "acq_entry",  mk(ACQ,   4'd3, 1'b0, 1'b0, 0), ALL);
    expectAt(22, "acq_win1",   mk(ACQ,   4'd3, 1'b0, 1'b0, 0), ALL);
    expectAt(38, "acq_win2",   mk(ACQ,   4'd3, 1'b0, 1'b0, 0), ALL);
    expectAt(39, "shift_in",   mk(SHIFT, 4'd8, 1'b1, 1'b0, 0), ALL);
    expectAt(42, "shift_last", mk(SHIFT, 4'd8, 1'b1, 1'b0, 0), ALL);
    expectAt(43, "track_in",   mk(TRACK, 4'd8, 1'b0, 1'b1, 0), ALL);

    // 4: two simultaneous carry+borrow rises in a TRACK window -> unlock
    toCyc(43);
    compared++;
    if (st !== 2'b11) begin
      mismatched++;
      $display("FAIL track_state: got %b", st);
    end
    compared++;
    if (lck !== 1'b1) begin
      mismatched++;
      $display("FAIL track_locked: got %b", lck);
    end
    expectAt(58, "track_wend", mk(TRACK, 4'd8, 1'b0, 1'b1, 0), ALL);
    expectAt(59, "unlock",     mk(ACQ,   4'd3, 1'b1, 1'b0, 4), ALL);
    expectAt(60, "unlock_clr", mk(ACQ,   4'd3, 1'b0, 1'b0, 4), ALL);
    toCyc(45); carry = 1'b1; borrow = 1'b1;
    toCyc(46); carry = 1'b0; borrow = 1'b0;
    toCyc(48); carry = 1'b1; borrow = 1'b1;
    toCyc(49); carry = 1'b0; borrow = 1'b0;

    // 3: noisy window resets quiet run; SHIFT only after window 3
    toCyc(59);
    expectAt(75,  "noisy_w1",  mk(ACQ,   4'd3, 1'b0, 1'b0, 3), ALL);
    expectAt(91,  "quiet_w2",  mk(ACQ,   4'd3, 1'b0, 1'b0, 0), ALL);
    expectAt(107, "quiet_w3",  mk(SHIFT, 4'd8, 1'b1, 1'b0, 0), ALL);
    expectAt(110, "settle_4",  mk(SHIFT, 4'd8, 1'b1, 1'b0, 0), ALL);
    expectAt(111, "track_2",   mk(TRACK, 4'd8, 1'b0, 1'b1, 0), ALL);
    for (int unsigned i = 60; i <= 65; i++) begin
      toCyc(i);
      carry = ((i - 60) % 2 == 0);
    end

    // 5: carry toggling every cycle -> unlock, then saturation in ACQ, no lock
    toCyc(111);
    expectAt(126, "track_wend2", mk(TRACK, 4'd8, 1'b0, 1'b1, 0), ALL);
    expectAt(127, "toggle_unl",  mk(ACQ,   4'd3, 1'b1, 1'b0, 8), ALL);
    expectAt(143, "toggle_sat",  mk(ACQ,   4'd3, 1'b0, 1'b0, 8), ALL);
    for (int unsigned i = 111; i <= 142; i++) begin
      toCyc(i);
      carry = ((i - 111) % 2 == 0);
    end

    // 6: enable drop coincides with the lock-qualifying window end
    expectAt(159, "quiet_a",   mk(ACQ,  4'd3, 1'b0, 1'b0, 0), ALL);
    expectAt(174, "pre_drop",  mk(ACQ,  4'd3, 1'b0, 1'b0, 0), ALL);
    expectAt(175, "drop_idle", mk(IDLE, 4'd3, 1'b1, 1'b0, 0), NOEV);
    expectAt(177, "idle_hold", mk(IDLE, 4'd3, 1'b1, 1'b0, 0), NOEV);
    toCyc(174);
    enable = 1'b0;
    toCyc(180);

    for (int unsigned i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    while (sb.size() > 0) begin
      c = sb.pop_front();
      compared++;
      mismatched++;
      $display("FAIL %s: never sampled, expected %h by cyc %0d", c.name, c.exp, c.t);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
